// File: rtl/ifetcher_stream.sv
// Pipelined instruction fetcher: keeps several in-order cache requests in flight,
// tags each response with its PC and buffers it in a credit-protected receive queue.
module ifetcher_stream #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              TIMEOUT         = 255
) (
    input  logic            iClk,
    input  logic            iResetn,
    input  logic            iJumpVld,
    input  logic [XLEN-1:0] iJumpPC,
    output logic            toCache_req,
    output logic [XLEN-1:0] toCache_pc,
    input  logic            fromCache_gnt,
    input  logic            fromCache_resp,
    input  logic [XLEN-1:0] fromCache_instr,
    output logic            oInstrVld,
    output logic [XLEN-1:0] oInstr,
    output logic [XLEN-1:0] oInstrPC,
    input  logic            iInstrRdy,
    output logic            oTimeoutFatal
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outs_q, outs_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tag_wr_q, tag_wr_d;
    logic [TW-1:0]   tag_rd_q, tag_rd_d;
    logic [FW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [15:0]     tcnt_q, tcnt_d;
    logic            fatal_q, fatal_d;

    logic [XLEN-1:0] tag_mem   [MAX_OUTSTANDING];
    logic [XLEN-1:0] instr_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];

    logic            accept;
    logic            resp;
    logic            push;
    logic            pop;
    logic [CW:0]     credit;

    // Credit counts queued entries plus live (non-squashed) requests still in flight.
    always_comb begin
        credit      = {1'b0, cnt_q} + {1'b0, outs_q} - {1'b0, drop_q};
        toCache_req = !fatal_q && !iJumpVld
                      && (outs_q < CW'(MAX_OUTSTANDING))
                      && (credit < (CW + 1)'(FIFO_DEPTH));
        toCache_pc  = pc_q;
        accept      = toCache_req && fromCache_gnt;
        resp        = fromCache_resp && (outs_q != '0);
        push        = resp && (drop_q == '0) && !iJumpVld;
        oInstrVld   = (cnt_q != '0);
        pop         = oInstrVld && iInstrRdy && !iJumpVld;
        oInstr      = oInstrVld ? instr_mem[rd_ptr_q] : '0;
        oInstrPC    = oInstrVld ? pc_mem[rd_ptr_q] : '0;
        oTimeoutFatal = fatal_q;
    end

    always_comb begin
        pc_d     = pc_q;
        outs_d   = outs_q + CW'(accept) - CW'(resp);
        drop_d   = drop_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        wr_ptr_d = push ? wr_ptr_q + FW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + FW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        tcnt_d   = tcnt_q;
        fatal_d  = fatal_q || (tcnt_q == 16'(TIMEOUT));

        if (accept) begin
            pc_d     = pc_q + XLEN'(4);
            tag_wr_d = (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + TW'(1);
        end
        if (resp) begin
            tag_rd_d = (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + TW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end

        // The tag queue survives a jump; only the squash count records what is now stale.
        if (iJumpVld) begin
            pc_d     = iJumpPC & ~XLEN'(3);
            drop_d   = outs_q - CW'(resp);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end

        if (resp || (outs_q == '0)) begin
            tcnt_d = '0;
        end else if (tcnt_q != 16'(TIMEOUT)) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            pc_q     <= RESET_PC;
            outs_q   <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tcnt_q   <= '0;
            fatal_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            outs_q   <= outs_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tcnt_q   <= tcnt_d;
            fatal_q  <= fatal_d;
        end
    end

    // Storage arrays need no reset: the pointers and counts decide what is valid.
    always_ff @(posedge iClk) begin
        if (accept) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (push) begin
            instr_mem[wr_ptr_q] <= fromCache_instr;
            pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
        end
    end

endmodule

// File: tb/tb_ifetcher_stream.sv
// Self-checking bench for ifetcher_stream: the bench acts as the cache and compares
// every cycle against a queue-based reference model of fetch, squash and delivery.
module tb_ifetcher_stream;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam int TMO   = 10;

    logic        iClk = 1'b0;
    logic        iResetn;
    logic        iJumpVld;
    logic [31:0] iJumpPC;
    logic        toCache_req;
    logic [31:0] toCache_pc;
    logic        fromCache_gnt;
    logic        fromCache_resp;
    logic [31:0] fromCache_instr;
    logic        oInstrVld;
    logic [31:0] oInstr;
    logic [31:0] oInstrPC;
    logic        iInstrRdy;
    logic        oTimeoutFatal;

    ifetcher_stream #(
        .XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)
    ) dut (
        .iClk(iClk), .iResetn(iResetn),
        .iJumpVld(iJumpVld), .iJumpPC(iJumpPC),
        .toCache_req(toCache_req), .toCache_pc(toCache_pc),
        .fromCache_gnt(fromCache_gnt), .fromCache_resp(fromCache_resp),
        .fromCache_instr(fromCache_instr),
        .oInstrVld(oInstrVld), .oInstr(oInstr), .oInstrPC(oInstrPC),
        .iInstrRdy(iInstrRdy), .oTimeoutFatal(oTimeoutFatal)
    );

    always #5 iClk = ~iClk;

    typedef struct { logic [31:0] pc; bit live; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    // Reference model: requests in flight (stale ones marked dead) and the delivery queue.
    infl_t       infl[$];
    ent_t        rq[$];
    logic [31:0] m_pc;
    int          m_tcnt;
    bit          m_fatal;

    bit          cur_jump, cur_gnt, cur_resp, cur_rdy;
    logic [31:0] cur_jpc;
    bit          exp_req, exp_vld;
    logic [31:0] exp_ipc, exp_instr;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        infl.delete();
        rq.delete();
        m_pc    = 32'h0;
        m_tcnt  = 0;
        m_fatal = 0;
    endtask

    task automatic do_reset();
        iResetn = 1'b0;
        iJumpVld = 0; iJumpPC = 0; fromCache_gnt = 0; fromCache_resp = 0;
        fromCache_instr = 0; iInstrRdy = 0;
        model_reset();
        repeat (2) @(posedge iClk);
        #1 iResetn = 1'b1;
    endtask

    // Modes: 0 = never, 1 = random, 2 = always. Returns at the falling edge.
    task automatic drive(input bit jmp, input logic [31:0] jpc, input int gm, input int rm, input int dm);
        int live;
        cur_jump = jmp;
        cur_jpc  = jpc;
        cur_gnt  = (gm == 2) || (gm == 1 && $urandom_range(0, 1) == 1);
        cur_resp = (infl.size() > 0) &&
                   ((rm == 2) || (rm == 1 && ($urandom_range(0, 2) != 0 || m_tcnt >= 4)));
        cur_rdy  = (dm == 2) || (dm == 1 && $urandom_range(0, 3) != 0);
        iJumpVld = jmp;
        iJumpPC  = jpc;
        fromCache_gnt  = cur_gnt;
        fromCache_resp = cur_resp;
        if (cur_resp) fromCache_instr = instr_of(infl[0].pc);
        else          fromCache_instr = $urandom();
        iInstrRdy = cur_rdy;
        live = 0;
        foreach (infl[k]) if (infl[k].live) live++;
        exp_req = !m_fatal && !jmp && (infl.size() < MAXO) && (rq.size() + live < DEPTH);
        exp_vld = (rq.size() > 0);
        exp_ipc   = exp_vld ? rq[0].pc : 32'h0;
        exp_instr = exp_vld ? rq[0].instr : 32'h0;
        @(negedge iClk);
    endtask

    task automatic commit();
        bit acc, pop;
        acc = exp_req && cur_gnt;
        pop = exp_vld && cur_rdy && !cur_jump;
        @(posedge iClk);
        #1;
        if (m_tcnt == TMO) m_fatal = 1;
        if (cur_resp || infl.size() == 0) m_tcnt = 0;
        else m_tcnt++;
        if (pop) void'(rq.pop_front());
        if (cur_resp) begin
            infl_t h;
            h = infl.pop_front();
            if (h.live && !cur_jump) rq.push_back('{h.pc, instr_of(h.pc)});
        end
        if (acc) begin
            infl.push_back('{m_pc, 1'b1});
            m_pc = m_pc + 32'd4;
        end
        if (cur_jump) begin
            rq.delete();
            foreach (infl[k]) infl[k].live = 0;
            m_pc = cur_jpc & 32'hFFFF_FFFC;
        end
    endtask

    task automatic test_reset();
        iResetn = 1'b0;
        iJumpVld = 0; iJumpPC = 0; fromCache_gnt = 0; fromCache_resp = 0;
        fromCache_instr = 0; iInstrRdy = 0;
        model_reset();
        #1;
        checks++;
        if (oInstrVld !== 1'b0 || oInstr !== 32'h0 || oInstrPC !== 32'h0 ||
            oTimeoutFatal !== 1'b0 || toCache_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_values got vld=%b instr=%h ipc=%h fatal=%b pc=%h required 0,0,0,0,0",
                     oInstrVld, oInstr, oInstrPC, oTimeoutFatal, toCache_pc);
        end
        @(posedge iClk);
        #1 iResetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 2, 2, 0);
            commit();
        end
        iResetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (oInstrVld !== 1'b0 || oInstrPC !== 32'h0 || toCache_pc !== 32'h0 || oTimeoutFatal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midop got vld=%b ipc=%h pc=%h fatal=%b required 0,0,0,0",
                     oInstrVld, oInstrPC, toCache_pc, oTimeoutFatal);
        end
        @(posedge iClk);
        #1 iResetn = 1'b1;
        drive(0, 0, 0, 0, 0);
        checks++;
        if (toCache_req !== 1'b1 || toCache_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_first_req got req=%b pc=%h required 1 00000000", toCache_req, toCache_pc);
        end
        commit();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 2, 2, 2);
            checks++;
            if (toCache_req !== exp_req || (exp_req && toCache_pc !== m_pc)) begin
                errors++;
                $display("[TB] FAIL stream_req cyc=%0d got req=%b pc=%h required req=%b pc=%h",
                         i, toCache_req, toCache_pc, exp_req, m_pc);
            end
            checks++;
            if (oInstrVld !== exp_vld || (exp_vld && (oInstrPC !== exp_ipc || oInstr !== exp_instr))) begin
                errors++;
                $display("[TB] FAIL stream_head cyc=%0d got vld=%b pc=%h instr=%h required vld=%b pc=%h instr=%h",
                         i, oInstrVld, oInstrPC, oInstr, exp_vld, exp_ipc, exp_instr);
            end
            if (i >= 2) begin
                checks++;
                if (oInstrVld !== 1'b1 || oInstrPC !== 32'(4 * (i - 2))) begin
                    errors++;
                    $display("[TB] FAIL stream_nobubble cyc=%0d got vld=%b pc=%h required vld=1 pc=%h",
                             i, oInstrVld, oInstrPC, 32'(4 * (i - 2)));
                end
            end
            commit();
        end
    endtask

    task automatic test_backpressure();
        int acc;
        logic [31:0] got[$];
        do_reset();
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 2, 2, 0);
            checks++;
            if (toCache_req !== exp_req) begin
                errors++;
                $display("[TB] FAIL bp_req cyc=%0d got %b required %b", i, toCache_req, exp_req);
            end
            if (toCache_req && fromCache_gnt) acc++;
            commit();
        end
        checks++;
        if (acc != DEPTH) begin
            errors++;
            $display("[TB] FAIL bp_accepts got %0d required %0d", acc, DEPTH);
        end
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 2, 2, 2);
            checks++;
            if (oInstrVld !== exp_vld || (exp_vld && (oInstrPC !== exp_ipc || oInstr !== exp_instr))) begin
                errors++;
                $display("[TB] FAIL bp_head cyc=%0d got vld=%b pc=%h instr=%h required vld=%b pc=%h instr=%h",
                         i, oInstrVld, oInstrPC, oInstr, exp_vld, exp_ipc, exp_instr);
            end
            if (oInstrVld) got.push_back(oInstrPC);
            if (toCache_req && fromCache_gnt) acc++;
            commit();
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got.size() <= k || got[k] !== 32'(4 * k)) begin
                errors++;
                $display("[TB] FAIL bp_order idx=%0d got %h required %h", k,
                         (got.size() > k) ? got[k] : 32'hxxxx_xxxx, 32'(4 * k));
            end
        end
        checks++;
        if (acc == 0) begin
            errors++;
            $display("[TB] FAIL bp_resume got 0 accepts required >0");
        end
    endtask

    task automatic test_jump_squash();
        bit seen;
        do_reset();
        drive(0, 0, 2, 0, 0); commit();
        drive(0, 0, 2, 2, 0); commit();
        drive(0, 0, 2, 2, 0); commit();
        drive(0, 0, 2, 0, 0); commit();
        drive(1, 32'h103, 2, 0, 0);
        checks++;
        if (toCache_req !== 1'b0 || oInstrVld !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jump_cycle got req=%b vld=%b required req=0 vld=1", toCache_req, oInstrVld);
        end
        commit();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 2, 2, 2);
            if (i == 0) begin
                checks++;
                if (oInstrVld !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL jump_flush got vld=%b required 0", oInstrVld);
                end
            end
            checks++;
            if (toCache_req !== exp_req || oInstrVld !== exp_vld ||
                (exp_vld && (oInstrPC !== exp_ipc || oInstr !== exp_instr))) begin
                errors++;
                $display("[TB] FAIL jump_stream cyc=%0d got req=%b vld=%b pc=%h required req=%b vld=%b pc=%h",
                         i, toCache_req, oInstrVld, oInstrPC, exp_req, exp_vld, exp_ipc);
            end
            if (oInstrVld && !seen) begin
                seen = 1;
                checks++;
                if (oInstrPC !== 32'h100 || oInstr !== instr_of(32'h100)) begin
                    errors++;
                    $display("[TB] FAIL jump_first got pc=%h instr=%h required pc=00000100 instr=%h",
                             oInstrPC, oInstr, instr_of(32'h100));
                end
            end
            commit();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL jump_delivered got none required an entry");
        end
    endtask

    task automatic test_jump_with_resp();
        bit seen;
        do_reset();
        drive(0, 0, 2, 0, 2); commit();
        drive(0, 0, 2, 0, 2); commit();
        drive(1, 32'h200, 2, 2, 2); commit();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 2, 2, 2);
            checks++;
            if (oInstrVld !== exp_vld || (exp_vld && (oInstrPC !== exp_ipc || oInstr !== exp_instr))) begin
                errors++;
                $display("[TB] FAIL jresp_head cyc=%0d got vld=%b pc=%h required vld=%b pc=%h",
                         i, oInstrVld, oInstrPC, exp_vld, exp_ipc);
            end
            if (oInstrVld && !seen) begin
                seen = 1;
                checks++;
                if (oInstrPC !== 32'h200) begin
                    errors++;
                    $display("[TB] FAIL jresp_first got pc=%h required 00000200", oInstrPC);
                end
            end
            commit();
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] got[$];
        do_reset();
        drive(1, 32'hFFFF_FFF9, 2, 2, 2); commit();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 2, 2, 2);
            checks++;
            if (oInstrVld !== exp_vld || (exp_vld && (oInstrPC !== exp_ipc || oInstr !== exp_instr))) begin
                errors++;
                $display("[TB] FAIL wrap_head cyc=%0d got vld=%b pc=%h required vld=%b pc=%h",
                         i, oInstrVld, oInstrPC, exp_vld, exp_ipc);
            end
            if (toCache_req && fromCache_gnt) got.push_back(toCache_pc);
            commit();
        end
        checks++;
        if (got.size() < 3 || got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_seq got %0d reqs first=%h,%h,%h required FFFFFFF8,FFFFFFFC,00000000",
                     got.size(), (got.size() > 0) ? got[0] : 32'hx,
                     (got.size() > 1) ? got[1] : 32'hx, (got.size() > 2) ? got[2] : 32'hx);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit j;
            logic [31:0] t;
            j = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            drive(j, t, 1, 1, 1);
            checks++;
            if (toCache_req !== exp_req || (exp_req && toCache_pc !== m_pc)) begin
                errors++;
                $display("[TB] FAIL rand_req cyc=%0d got req=%b pc=%h required req=%b pc=%h",
                         i, toCache_req, toCache_pc, exp_req, m_pc);
            end
            checks++;
            if (oInstrVld !== exp_vld || (exp_vld && (oInstrPC !== exp_ipc || oInstr !== exp_instr))) begin
                errors++;
                $display("[TB] FAIL rand_head cyc=%0d got vld=%b pc=%h instr=%h required vld=%b pc=%h instr=%h",
                         i, oInstrVld, oInstrPC, oInstr, exp_vld, exp_ipc, exp_instr);
            end
            checks++;
            if (oTimeoutFatal !== m_fatal) begin
                errors++;
                $display("[TB] FAIL rand_fatal cyc=%0d got %b required %b", i, oTimeoutFatal, m_fatal);
            end
            commit();
        end
    endtask

    task automatic test_timeout();
        int drained;
        do_reset();
        drive(0, 0, 2, 0, 0); commit();
        drive(0, 0, 2, 2, 0); commit();
        drive(0, 0, 2, 2, 0); commit();
        for (int k = 0; k < 14; k++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (oTimeoutFatal !== m_fatal) begin
                errors++;
                $display("[TB] FAIL tmo_model k=%0d got %b required %b", k, oTimeoutFatal, m_fatal);
            end
            if (k == 10 || k == 11) begin
                checks++;
                if (oTimeoutFatal !== (k == 11)) begin
                    errors++;
                    $display("[TB] FAIL tmo_edge k=%0d got %b required %b", k, oTimeoutFatal, k == 11);
                end
            end
            commit();
        end
        drained = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 2, 0, 2);
            checks++;
            if (toCache_req !== 1'b0 || oTimeoutFatal !== 1'b1) begin
                errors++;
                $display("[TB] FAIL tmo_block cyc=%0d got req=%b fatal=%b required req=0 fatal=1",
                         i, toCache_req, oTimeoutFatal);
            end
            checks++;
            if (oInstrVld !== exp_vld || (exp_vld && (oInstrPC !== exp_ipc || oInstr !== exp_instr))) begin
                errors++;
                $display("[TB] FAIL tmo_drain cyc=%0d got vld=%b pc=%h required vld=%b pc=%h",
                         i, oInstrVld, oInstrPC, exp_vld, exp_ipc);
            end
            if (oInstrVld) drained++;
            commit();
        end
        checks++;
        if (drained != 2) begin
            errors++;
            $display("[TB] FAIL tmo_drained got %0d required 2", drained);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_squash();
        test_jump_with_resp();
        test_pc_wrap();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
